// File: rtl/cpu_types.sv
// Shared types for the RS / FU / CDB slice: tags, the CDB payload
// and the scheduler state encoding.
package cpu_types;

  typedef logic [3:0] RS_tag_type;

  localparam RS_tag_type INVALID = 4'hF;

  typedef struct packed {
    RS_tag_type  tag;
    logic [31:0] data;
  } cdb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rs_fu_scheduler_if.sv
// RS pool / FU / CDB signals seen by the scheduler.
// master: RS pool, FU and arbiter side; slave: the scheduler.
interface rs_fu_scheduler_if
  import cpu_types::*;
#(
  parameter int NUM_RS = 4
) ();

  logic [NUM_RS-1:0]      rs_busy;
  logic [NUM_RS-1:0]      rs_ready;
  RS_tag_type [NUM_RS-1:0] rs_tag;
  logic                   fu_ready;
  logic                   fu_start;
  logic [NUM_RS-1:0]      issue_sel;
  logic                   fu_done;
  logic [31:0]            fu_result;
  logic                   cdb_req;
  logic                   cdb_grant;
  cdb_t                   cdb_out;
  logic [NUM_RS-1:0]      rs_done;

  modport master (
    output rs_busy, rs_ready, rs_tag,
    output fu_ready, fu_done, fu_result,
    output cdb_grant,
    input  fu_start, issue_sel,
    input  cdb_req, cdb_out, rs_done
  );

  modport slave (
    input  rs_busy, rs_ready, rs_tag,
    input  fu_ready, fu_done, fu_result,
    input  cdb_grant,
    output fu_start, issue_sel,
    output cdb_req, cdb_out, rs_done
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of eligible at or
// above ptr, wrapping. Ports: eligible, ptr in; grant (one-hot), any out.
module rr_picker #(
  parameter int NUM_RS = 4,
  parameter int PW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
  input  logic [NUM_RS-1:0] eligible,
  input  logic [PW-1:0]     ptr,
  output logic [NUM_RS-1:0] grant,
  output logic              any
);

  // Outer loop walks search distance from ptr; inner loop keeps
  // every bit select at a constant index.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int k = 0; k < NUM_RS; k++) begin
      for (int i = 0; i < NUM_RS; i++) begin
        if (!any && eligible[i] &&
            ((int'(ptr) + k) % NUM_RS) == i) begin
          grant[i] = 1'b1;
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rs_fu_scheduler.sv
// Shares one non-pipelined FU among NUM_RS stations and writes back on the CDB.
// Ports: CLK, RST_N, flush, bus (slave side of rs_fu_scheduler_if).
module rs_fu_scheduler
  import cpu_types::*;
#(
  parameter int NUM_RS = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                flush,
  rs_fu_scheduler_if.slave    bus
);

  localparam int PW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  sched_state_t      state;
  logic [PW-1:0]     ptr;
  logic [NUM_RS-1:0] sel_q;
  RS_tag_type        tag_q;
  logic [31:0]       data_q;

  logic [NUM_RS-1:0] eligible;
  logic [NUM_RS-1:0] pick;
  logic              any;
  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     ptr_nxt;
  RS_tag_type        pick_tag;
  logic              issue;

  assign eligible = bus.rs_busy & bus.rs_ready;

  rr_picker #(
    .NUM_RS (NUM_RS),
    .PW     (PW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (pick),
    .any      (any)
  );

  always_comb begin
    pick_idx = '0;
    pick_tag = INVALID;
    for (int i = 0; i < NUM_RS; i++) begin
      if (pick[i]) begin
        pick_idx = PW'(i);
        pick_tag = bus.rs_tag[i];
      end
    end
  end

  assign ptr_nxt = (pick_idx == PW'(NUM_RS - 1)) ?
                   '0 : pick_idx + PW'(1);

  // A flush cycle never starts the FU: the scheduler would not follow it.
  assign bus.fu_start = (state == IDLE) & any & ~flush;
  assign issue        = bus.fu_start & bus.fu_ready;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= IDLE;
      ptr    <= '0;
      sel_q  <= '0;
      tag_q  <= INVALID;
      data_q <= '0;
    end else if (flush) begin
      state  <= IDLE;
      sel_q  <= '0;
      tag_q  <= INVALID;
      data_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue) begin
            state <= EXEC;
            sel_q <= pick;
            tag_q <= pick_tag;
            ptr   <= ptr_nxt;
          end
        end
        EXEC: begin
          if (bus.fu_done) begin
            data_q <= bus.fu_result;
            state  <= WB;
          end
        end
        WB: begin
          if (bus.cdb_grant) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.issue_sel   = '0;
    bus.cdb_req     = 1'b0;
    bus.cdb_out.tag  = INVALID;
    bus.cdb_out.data = '0;
    bus.rs_done     = '0;
    unique case (state)
      IDLE: bus.issue_sel = pick;
      EXEC: bus.issue_sel = sel_q;
      WB: begin
        bus.cdb_req      = 1'b1;
        bus.cdb_out.tag  = tag_q;
        bus.cdb_out.data = data_q;
        if (bus.cdb_grant && !flush) bus.rs_done = sel_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST_N) begin
      assert ($onehot0(bus.issue_sel))
        else $error("issue_sel not one-hot");
      assert ($onehot0(bus.rs_done))
        else $error("rs_done not one-hot");
      assert (!bus.cdb_req || state == WB)
        else $error("cdb_req outside WB");
    end
  end

endmodule

// File: tb/tb_rs_fu_scheduler.sv
// Directed bench for rs_fu_scheduler with a CDB scoreboard.
// Expected broadcasts are queued at fu_done and popped at grant.
module tb_rs_fu_scheduler;
  import cpu_types::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  RS_tag_type tags [4];
  cdb_t       exp_q [$];
  logic [3:0] done_q [$];

  rs_fu_scheduler_if #(.NUM_RS(4)) bus ();

  rs_fu_scheduler #(.NUM_RS(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string t, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  task automatic set_elig(logic [3:0] e);
    bus.rs_busy  = e;
    bus.rs_ready = e;
  endtask

  function automatic logic [3:0] oh(int i);
    return 4'(1 << i);
  endfunction

  task automatic do_issue(int idx);
    bus.fu_ready = 1'b1;
    #1;
    chk("iss_start", 64'(bus.fu_start), 64'(1));
    chk("iss_sel", 64'(bus.issue_sel), 64'(oh(idx)));
    chk("iss_req", 64'(bus.cdb_req), 64'(0));
    cur = idx;
    tick();
    bus.fu_ready = 1'b0;
  endtask

  task automatic do_exec(int d, logic [31:0] data);
    cdb_t e;
    for (int k = 0; k < d; k++) begin
      #1;
      chk("ex_start", 64'(bus.fu_start), 64'(0));
      chk("ex_sel", 64'(bus.issue_sel), 64'(oh(cur)));
      chk("ex_req", 64'(bus.cdb_req), 64'(0));
      tick();
    end
    bus.fu_done   = 1'b1;
    bus.fu_result = data;
    #1;
    chk("ex_sel", 64'(bus.issue_sel), 64'(oh(cur)));
    e.tag  = tags[cur];
    e.data = data;
    exp_q.push_back(e);
    done_q.push_back(oh(cur));
    tick();
    bus.fu_done   = 1'b0;
    bus.fu_result = '0;
  endtask

  task automatic do_wb(int g);
    cdb_t       e;
    logic [3:0] ed;
    for (int k = 0; k < g; k++) begin
      #1;
      chk("wb_req", 64'(bus.cdb_req), 64'(1));
      chk("wb_out", 64'(bus.cdb_out), 64'(exp_q[0]));
      chk("wb_start", 64'(bus.fu_start), 64'(0));
      chk("wb_sel", 64'(bus.issue_sel), 64'(0));
      chk("wb_done", 64'(bus.rs_done), 64'(0));
      tick();
    end
    bus.cdb_grant = 1'b1;
    #1;
    e  = exp_q.pop_front();
    ed = done_q.pop_front();
    chk("gnt_req", 64'(bus.cdb_req), 64'(1));
    chk("gnt_out", 64'(bus.cdb_out), 64'(e));
    chk("gnt_done", 64'(bus.rs_done), 64'(ed));
    chk("gnt_start", 64'(bus.fu_start), 64'(0));
    tick();
    bus.cdb_grant = 1'b0;
    #1;
    chk("post_done", 64'(bus.rs_done), 64'(0));
    chk("post_req", 64'(bus.cdb_req), 64'(0));
    chk("post_tag", 64'(bus.cdb_out.tag), 64'(INVALID));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    cdb_t idle_out;
    idle_out.tag  = INVALID;
    idle_out.data = '0;
    tags[0] = 4'h5;
    tags[1] = 4'h6;
    tags[2] = 4'h7;
    tags[3] = 4'h8;
    bus.rs_tag    = {tags[3], tags[2], tags[1], tags[0]};
    bus.rs_busy   = '0;
    bus.rs_ready  = '0;
    bus.fu_ready  = 1'b0;
    bus.fu_done   = 1'b0;
    bus.fu_result = '0;
    bus.cdb_grant = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_req", 64'(bus.cdb_req), 64'(0));
    chk("rst_done", 64'(bus.rs_done), 64'(0));
    chk("rst_out", 64'(bus.cdb_out), 64'(idle_out));
    chk("rst_start", 64'(bus.fu_start), 64'(0));
    rst_n = 1'b1;
    tick();

    // single op, RS0 busy but not ready
    bus.rs_busy  = 4'b0011;
    bus.rs_ready = 4'b1110;
    do_issue(1);
    do_exec(2, 32'h0000_1234);
    do_wb(1);

    // reset while in WB
    set_elig(4'b0100);
    do_issue(2);
    do_exec(0, 32'hDEAD_BEEF);
    #1;
    chk("mid_req", 64'(bus.cdb_req), 64'(1));
    rst_n = 1'b0;
    tick();
    chk("mwb_req", 64'(bus.cdb_req), 64'(0));
    chk("mwb_done", 64'(bus.rs_done), 64'(0));
    chk("mwb_out", 64'(bus.cdb_out), 64'(idle_out));
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    done_q.delete();
    set_elig(4'b1001);
    do_issue(0);
    do_exec(1, 32'h1111_0000);
    do_wb(0);

    // round robin, all eligible
    do_reset();
    set_elig(4'b1111);
    for (int i = 0; i < 5; i++) begin
      do_issue(i % 4);
      do_exec(0, 32'hA000_0000 + 32'(i));
      do_wb(0);
    end

    // round robin, RS0 and RS2
    do_reset();
    set_elig(4'b0101);
    for (int i = 0; i < 4; i++) begin
      do_issue((i % 2) * 2);
      do_exec(0, 32'hB000_0000 + 32'(i));
      do_wb(0);
    end

    // backpressure on RS3
    set_elig(4'b1000);
    bus.fu_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_start", 64'(bus.fu_start), 64'(1));
      chk("bp_sel", 64'(bus.issue_sel), 64'(4'b1000));
      chk("bp_req", 64'(bus.cdb_req), 64'(0));
      tick();
    end
    set_elig(4'b1001);
    do_issue(3);
    do_exec(0, 32'hC0DE_0003);
    do_wb(0);

    // delayed grant, RS0 turns eligible during WB
    set_elig(4'b0010);
    do_issue(1);
    do_exec(0, 32'h5555_AAAA);
    set_elig(4'b0011);
    do_wb(5);
    do_issue(0);
    do_exec(0, 32'h0000_0042);
    do_wb(0);

    // flush in EXEC, late fu_done ignored
    set_elig(4'b0100);
    do_issue(2);
    flush = 1'b1;
    #1;
    chk("fl_done", 64'(bus.rs_done), 64'(0));
    tick();
    flush = 1'b0;
    set_elig(4'b0000);
    #1;
    chk("fl_req0", 64'(bus.cdb_req), 64'(0));
    tick();
    bus.fu_done   = 1'b1;
    bus.fu_result = 32'hBAD0_BAD0;
    #1;
    chk("fl_req1", 64'(bus.cdb_req), 64'(0));
    tick();
    bus.fu_done   = 1'b0;
    bus.fu_result = '0;
    #1;
    chk("fl_req2", 64'(bus.cdb_req), 64'(0));
    chk("fl_done2", 64'(bus.rs_done), 64'(0));
    set_elig(4'b0010);
    do_issue(1);
    do_exec(0, 32'h0BAD_F00D);
    do_wb(0);

    // flush coincident with grant
    set_elig(4'b1000);
    do_issue(3);
    do_exec(0, 32'h7777_7777);
    #1;
    chk("fg_req", 64'(bus.cdb_req), 64'(1));
    bus.cdb_grant = 1'b1;
    flush = 1'b1;
    #1;
    chk("fg_done", 64'(bus.rs_done), 64'(0));
    void'(exp_q.pop_front());
    void'(done_q.pop_front());
    tick();
    bus.cdb_grant = 1'b0;
    flush = 1'b0;
    set_elig(4'b0001);
    #1;
    chk("fg_req1", 64'(bus.cdb_req), 64'(0));
    chk("fg_done1", 64'(bus.rs_done), 64'(0));
    chk("fg_start", 64'(bus.fu_start), 64'(1));
    chk("fg_sel", 64'(bus.issue_sel), 64'(4'b0001));
    do_issue(0);
    do_exec(0, 32'h0000_0099);
    do_wb(2);

    chk("q_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
